// File: rtl/instr_fetch_if.sv
// Instruction-memory read bus: word address out, one-cycle ack with data back.
interface instr_fetch_if;
    logic        req;
    logic [15:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: drives next-PC, reads instruction memory and fills IF/ID,
// using a one-entry skid under decode stall and draining a request on redirect.
module instr_fetch (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         i_pc_cur,
    output logic [15:0]         o_pc_next,
    instr_fetch_if.master       imem,
    input  logic                i_stall,
    input  logic                i_redirect,
    input  logic [15:0]         i_redirect_pc,
    output logic                o_ifid_valid,
    output logic [31:0]         o_ifid_instr,
    output logic [15:0]         o_ifid_pc
);
    // state | meaning
    // FETCH | request outstanding at pc_cur, IF/ID may accept the result
    // FULL  | IF/ID stalled and skid occupied, no request issued
    // DRAIN | redirected mid-request; wait for the stale ack, then jump
    typedef enum logic [1:0] {S_FETCH, S_FULL, S_DRAIN} state_t;

    state_t      r_state;
    logic        r_ifid_valid;
    logic [31:0] r_ifid_instr;
    logic [15:0] r_ifid_pc;
    logic [31:0] r_skid_instr;
    logic [15:0] r_skid_pc;
    logic [15:0] r_pending_pc;

    logic        w_req;
    logic [15:0] w_pc_next;
    logic        w_consumed;

    assign w_consumed = r_ifid_valid & ~i_stall;

    always_comb begin
        w_req     = 1'b0;
        w_pc_next = i_pc_cur;
        if (rst) begin
            w_pc_next = 16'h0000;
        end else begin
            case (r_state)
                S_FETCH: begin
                    w_req = 1'b1;
                    if (imem.ack)
                        w_pc_next = i_redirect ? i_redirect_pc : i_pc_cur + 16'd1;
                end
                S_FULL: begin
                    if (i_redirect)
                        w_pc_next = i_redirect_pc;
                end
                S_DRAIN: begin
                    w_req = 1'b1;
                    if (imem.ack)
                        w_pc_next = i_redirect ? i_redirect_pc : r_pending_pc;
                end
                default: w_pc_next = i_pc_cur;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= 32'h0;
            r_ifid_pc    <= 16'h0;
            r_skid_instr <= 32'h0;
            r_skid_pc    <= 16'h0;
            r_pending_pc <= 16'h0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem.ack) begin
                        if (i_redirect) begin
                            r_ifid_valid <= 1'b0;
                        end else if (!r_ifid_valid || !i_stall) begin
                            r_ifid_instr <= imem.rdata;
                            r_ifid_pc    <= i_pc_cur;
                            r_ifid_valid <= 1'b1;
                        end else begin
                            r_skid_instr <= imem.rdata;
                            r_skid_pc    <= i_pc_cur;
                            r_state      <= S_FULL;
                        end
                    end else if (i_redirect) begin
                        r_pending_pc <= i_redirect_pc;
                        r_ifid_valid <= 1'b0;
                        r_state      <= S_DRAIN;
                    end else if (w_consumed) begin
                        r_ifid_valid <= 1'b0;
                    end
                end
                S_FULL: begin
                    if (i_redirect) begin
                        r_ifid_valid <= 1'b0;
                        r_state      <= S_FETCH;
                    end else if (!i_stall) begin
                        r_ifid_instr <= r_skid_instr;
                        r_ifid_pc    <= r_skid_pc;
                        r_ifid_valid <= 1'b1;
                        r_state      <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    // The stale read is discarded; the jump target is taken from the PC path.
                    if (imem.ack)
                        r_state <= S_FETCH;
                    else if (i_redirect)
                        r_pending_pc <= i_redirect_pc;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign imem.req     = w_req;
    assign imem.addr    = i_pc_cur;
    assign o_pc_next    = w_pc_next;
    assign o_ifid_valid = r_ifid_valid;
    assign o_ifid_instr = r_ifid_instr;
    assign o_ifid_pc    = r_ifid_pc;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: PC register and memory modelled here,
// per-cycle vectors with hand-computed expectations.
module tb_instr_fetch;
    logic        clk;
    logic        rst;
    logic [15:0] pc_cur;
    logic [15:0] pc_next;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [15:0] ifid_pc;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_if imem();

    instr_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .i_pc_cur      (pc_cur),
        .o_pc_next     (pc_next),
        .imem          (imem),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_ifid_valid  (ifid_valid),
        .o_ifid_instr  (ifid_instr),
        .o_ifid_pc     (ifid_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter register and memory contents (word at addr = 0x1000_0000 + addr).
    always_ff @(posedge clk) pc_cur <= pc_next;
    assign imem.rdata = 32'h1000_0000 + {16'h0, imem.addr};

    typedef struct {
        logic        ack;
        logic        stall;
        logic        redir;
        logic [15:0] rpc;
        logic [15:0] e_pcn;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_v;
        logic [15:0] e_ipc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ack, input logic stl, input logic rd, input logic [15:0] rpc,
                       input logic [15:0] pcn, input logic req, input logic [15:0] addr,
                       input logic v, input logic [15:0] ipc);
        vec_t t;
        t.ack = ack; t.stall = stl; t.redir = rd; t.rpc = rpc;
        t.e_pcn = pcn; t.e_req = req; t.e_addr = addr; t.e_v = v; t.e_ipc = ipc;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ack, input logic stl, input logic rd,
                         input logic [15:0] rpc);
        @(negedge clk);
        rst = r; imem.ack = ack; stall = stl; redirect = rd; redirect_pc = rpc;
        #1;
    endtask

    initial begin
        rst = 1'b1; imem.ack = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;

        // ack stall rd rpc | pc_next req addr valid ifid_pc
        add(1,0,0,16'h0000, 16'h0001,1,16'h0000, 0,16'h0000);
        add(1,0,0,16'h0000, 16'h0002,1,16'h0001, 1,16'h0000);
        add(1,0,0,16'h0000, 16'h0003,1,16'h0002, 1,16'h0001);
        add(1,0,0,16'h0000, 16'h0004,1,16'h0003, 1,16'h0002);
        add(1,0,0,16'h0000, 16'h0005,1,16'h0004, 1,16'h0003);
        add(0,0,0,16'h0000, 16'h0005,1,16'h0005, 1,16'h0004);
        add(0,0,0,16'h0000, 16'h0005,1,16'h0005, 0,16'h0000);
        add(0,0,0,16'h0000, 16'h0005,1,16'h0005, 0,16'h0000);
        add(1,0,0,16'h0000, 16'h0006,1,16'h0005, 0,16'h0000);
        add(1,0,1,16'h0010, 16'h0010,1,16'h0006, 1,16'h0005);
        add(1,1,0,16'h0000, 16'h0011,1,16'h0010, 0,16'h0000);
        add(1,1,0,16'h0000, 16'h0012,1,16'h0011, 1,16'h0010);
        add(0,1,0,16'h0000, 16'h0012,0,16'h0012, 1,16'h0010);
        add(0,1,0,16'h0000, 16'h0012,0,16'h0012, 1,16'h0010);
        add(0,0,0,16'h0000, 16'h0012,0,16'h0012, 1,16'h0010);
        add(1,0,0,16'h0000, 16'h0013,1,16'h0012, 1,16'h0011);
        add(0,0,0,16'h0000, 16'h0013,1,16'h0013, 1,16'h0012);
        add(0,0,0,16'h0000, 16'h0013,1,16'h0013, 0,16'h0000);
        add(0,0,1,16'h0040, 16'h0013,1,16'h0013, 0,16'h0000);
        add(0,0,1,16'h0080, 16'h0013,1,16'h0013, 0,16'h0000);
        add(1,0,0,16'h0000, 16'h0080,1,16'h0013, 0,16'h0000);
        add(0,0,1,16'h0040, 16'h0080,1,16'h0080, 0,16'h0000);
        add(0,0,0,16'h0000, 16'h0080,1,16'h0080, 0,16'h0000);
        add(1,0,0,16'h0000, 16'h0040,1,16'h0080, 0,16'h0000);
        add(1,0,1,16'hFFFF, 16'hFFFF,1,16'h0040, 0,16'h0000);
        add(1,0,0,16'h0000, 16'h0000,1,16'hFFFF, 0,16'h0000);
        add(0,0,0,16'h0000, 16'h0000,1,16'h0000, 1,16'hFFFF);
        add(1,1,0,16'h0000, 16'h0001,1,16'h0000, 0,16'h0000);
        add(1,1,0,16'h0000, 16'h0002,1,16'h0001, 1,16'h0000);
        add(0,1,1,16'h0020, 16'h0020,0,16'h0002, 1,16'h0000);
        add(1,0,0,16'h0000, 16'h0021,1,16'h0020, 0,16'h0000);
        add(0,0,0,16'h0000, 16'h0021,1,16'h0021, 1,16'h0020);
        add(1,1,0,16'h0000, 16'h0022,1,16'h0021, 0,16'h0000);
        add(1,1,0,16'h0000, 16'h0023,1,16'h0022, 1,16'h0021);
        add(0,1,0,16'h0000, 16'h0023,0,16'h0023, 1,16'h0021);

        // Reset: two cycles, values checked in the second once pc_cur has loaded 0.
        drive(1,0,0,0,16'h0);
        check("rst pc_next", {16'h0, pc_next}, 32'h0);
        check("rst req", {31'h0, imem.req}, 32'h0);
        drive(1,1,0,0,16'h0);
        check("rst pc_next ack", {16'h0, pc_next}, 32'h0);
        check("rst req ack", {31'h0, imem.req}, 32'h0);
        check("rst addr", {16'h0, imem.addr}, 32'h0);
        check("rst valid", {31'h0, ifid_valid}, 32'h0);
        check("rst instr", ifid_instr, 32'h0);
        check("rst ifid_pc", {16'h0, ifid_pc}, 32'h0);

        foreach (vecs[i]) begin
            drive(0, vecs[i].ack, vecs[i].stall, vecs[i].redir, vecs[i].rpc);
            check($sformatf("row%0d pc_next", i), {16'h0, pc_next}, {16'h0, vecs[i].e_pcn});
            check($sformatf("row%0d req", i), {31'h0, imem.req}, {31'h0, vecs[i].e_req});
            check($sformatf("row%0d addr", i), {16'h0, imem.addr}, {16'h0, vecs[i].e_addr});
            check($sformatf("row%0d valid", i), {31'h0, ifid_valid}, {31'h0, vecs[i].e_v});
            if (vecs[i].e_v) begin
                check($sformatf("row%0d ifid_pc", i), {16'h0, ifid_pc}, {16'h0, vecs[i].e_ipc});
                check($sformatf("row%0d ifid_instr", i), ifid_instr,
                      32'h1000_0000 + {16'h0, vecs[i].e_ipc});
            end
        end

        // Reset while FULL with stall held: combinational outputs forced, then clean FETCH.
        drive(1,0,1,0,16'h0);
        check("fullrst pc_next", {16'h0, pc_next}, 32'h0);
        check("fullrst req", {31'h0, imem.req}, 32'h0);
        drive(0,0,1,0,16'h0);
        check("fullrst valid", {31'h0, ifid_valid}, 32'h0);
        check("fullrst req after", {31'h0, imem.req}, 32'h1);
        check("fullrst addr", {16'h0, imem.addr}, 32'h0);
        check("fullrst pc_next after", {16'h0, pc_next}, 32'h0);
        check("fullrst ifid_pc", {16'h0, ifid_pc}, 32'h0);
        drive(0,1,1,0,16'h0);
        check("fullrst fetch resumes", {16'h0, pc_next}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage: the producer side of the program counter register. Observes the current PC and computes the next PC every cycle. Issues word reads to instruction memory over a req/ack handshake and delivers fetched instructions into the IF/ID pipeline register. Handles decode back-pressure through a one-entry skid buffer and flushes on branch redirects.

## Interface
Parameters:
- None. PC is 16 bits, word-addressed; instructions are 32 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- pc_cur  in  16  current PC, from the program counter register output
- pc_next  out  16  next PC, to the program counter register input
- imem_req  out  1  memory read request, combinational
- imem_addr  out  16  read address; always equals pc_cur
- imem_ack  in  1  one-cycle read-complete pulse; imem_rdata is valid in the same cycle
- imem_rdata  in  32  read data
- stall  in  1  decode cannot accept; IF/ID is consumed in a cycle with ifid_valid=1 and stall=0
- redirect  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  16  redirect target
- ifid_valid  out  1  IF/ID holds a valid instruction
- ifid_instr  out  32  IF/ID instruction
- ifid_pc  out  16  PC of ifid_instr

## Operation
- The PC register loads pc_next on every clock. To hold the PC, the block drives pc_next = pc_cur.
- Memory protocol:
  - imem_req stays high until the cycle in which imem_ack is sampled high.
  - A new request may begin in the cycle after the ack.
  - The address (pc_cur) must not change while a request is outstanding.
- States are FETCH, FULL and DRAIN. Reset enters FETCH.
- FETCH: imem_req=1.
  - ack=1, redirect=1: discard rdata; pc_next=redirect_pc; ifid_valid<=0; stay in FETCH.
  - ack=1, redirect=0, and IF/ID is free or being consumed (ifid_valid=0 or stall=0): ifid<={rdata, pc_cur}; ifid_valid<=1; pc_next=pc_cur+1.
  - ack=1, redirect=0, ifid_valid=1 and stall=1: skid<={rdata, pc_cur}; pc_next=pc_cur+1; go to FULL.
  - ack=0, redirect=1: pending_pc<=redirect_pc; pc_next=pc_cur; ifid_valid<=0; go to DRAIN.
  - ack=0, redirect=0: pc_next=pc_cur; if IF/ID is consumed, ifid_valid<=0.
- FULL: imem_req=0; pc_next=pc_cur.
  - redirect=1: drop the skid; ifid_valid<=0; pc_next=redirect_pc; go to FETCH.
  - stall=0: ifid<=skid; ifid_valid<=1; go to FETCH.
- DRAIN: imem_req=1; pc_next=pc_cur; ifid_valid stays 0.
  - redirect=1 without ack: pending_pc<=redirect_pc (the latest redirect wins).
  - ack=1: discard rdata; pc_next = redirect_pc if redirect=1, otherwise pending_pc; go to FETCH.
- Redirect has priority over stall. Any redirect clears ifid_valid on the next edge.
- Arithmetic: pc_cur+1 is 16-bit modulo, so 0xFFFF wraps to 0x0000.

## Timing
- While rst=1, combinationally: pc_next=0x0000 and imem_req=0.
- On the rst edge: state=FETCH, ifid_valid=0, ifid_instr=0, ifid_pc=0, skid=0, pending_pc=0.
- Reset asserted mid-request abandons the request. Memory must tolerate req dropping under reset.
- First cycle after reset: imem_req=1, imem_addr=0x0000.
- Latency: an ack in cycle n gives ifid_valid=1 in n+1, and the PC advances at the n edge.
- Throughput: with ack in the same cycle as req, one instruction per cycle.
- Redirect in cycle n with no outstanding request (or with ack in n): pc_cur=redirect_pc in n+1, and the fetch of the target is issued in n+1.
- Never: two acks per request, or a change of imem_addr while imem_req=1 and no ack has been seen.

## Test plan
- Reset, then ack every cycle with rdata=0x1000_0000+addr, stall=0 → ifid_pc = 0,1,2,3 on consecutive cycles starting the cycle after the first ack; ifid_instr matches.
- Ack delayed 3 cycles → imem_addr=pc_cur held at 0x0005 for 4 cycles, pc_next=0x0005; then ifid_pc=0x0005.
- Stall held high while two acks arrive (addresses 0x10, 0x11) → ifid keeps 0x10, skid takes 0x11, req=0. Release stall → ifid_pc=0x11 one cycle later, fetch resumes at 0x12.
- Redirect to 0x0040 two cycles into a 4-cycle ack wait → state DRAIN, ack rdata discarded, ifid_valid=0, next request addr=0x0040. A second redirect to 0x0080 during DRAIN → next request addr=0x0080.
- pc_cur=0xFFFF with ack → pc_next=0x0000 and ifid_pc=0xFFFF.
- rst asserted while in FULL with stall=1 → next cycle ifid_valid=0, state FETCH, pc_next=0x0000 during rst.
